// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: default 640x480@60 mode, sync bundle type
// and the polarity helper used by the timing generator and its delay line.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CLK_DIV  = 2;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } sync_t;

  // Output level of a sync line given its asserted polarity.
  function automatic logic sync_level(input logic pol, input logic active);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster output bundle of the VGA timing generator; the generator drives the
// master side, the renderer / game logic listens on the slave side.
interface vga_timing_if #(
  parameter int COL_W = 10,
  parameter int ROW_W = 10
);
  logic             pix_en;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             HS;
  logic             VS;
  logic             blank;
  logic             frame_start;

  modport master (output pix_en, col, row, HS, VS, blank, frame_start);
  modport slave  (input  pix_en, col, row, HS, VS, blank, frame_start);
endinterface

// File: rtl/vga_sync_pipe.sv
// Delay line for the HS/VS/blank bundle, advancing only on the pixel strobe
// so the sync signals line up with a pipelined pixel renderer.
module vga_sync_pipe
  import vga_pkg::*;
#(
  parameter int    DEPTH   = 2,
  parameter sync_t RST_VAL = '{hs: 1'b1, vs: 1'b1, blank: 1'b1}
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  sync_t din,
  output sync_t dout
);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      sync_t src;
      sync_t stage_d;
      sync_t stage_q;

      if (gi == 0) begin : g_head
        assign src = din;
      end else begin : g_tail
        assign src = g_stage[gi-1].stage_q;
      end

      always_comb begin
        stage_d = stage_q;
        if (en) begin
          stage_d = src;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stage_q <= RST_VAL;
        end else begin
          stage_q <= stage_d;
        end
      end
    end
  endgenerate

  assign dout = g_stage[DEPTH-1].stage_q;

endmodule

// File: rtl/vga_timing.sv
// Parametrised VGA raster timing generator (pixel divider, H/V counters, sync).
// Define VGA_SYNC_PIPE_EN to delay HS/VS/blank by PIPE_DEPTH pixel strobes.
module vga_timing
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE   = DEF_H_ACTIVE,
  parameter int   H_FP       = DEF_H_FP,
  parameter int   H_SYNC     = DEF_H_SYNC,
  parameter int   H_BP       = DEF_H_BP,
  parameter int   V_ACTIVE   = DEF_V_ACTIVE,
  parameter int   V_FP       = DEF_V_FP,
  parameter int   V_SYNC     = DEF_V_SYNC,
  parameter int   V_BP       = DEF_V_BP,
  parameter int   CLK_DIV    = DEF_CLK_DIV,
  parameter logic HS_POL     = 1'b0,
  parameter logic VS_POL     = 1'b0,
  parameter int   PIPE_DEPTH = 2
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  vga_timing_if.master vif
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int COL_W    = $clog2(H_TOTAL);
  localparam int ROW_W    = $clog2(V_TOTAL);
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_TOTAL - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_TOTAL - 1);
  localparam sync_t SYNC_IDLE = '{hs:    sync_level(HS_POL, 1'b0),
                                  vs:    sync_level(VS_POL, 1'b0),
                                  blank: 1'b1};

  logic [DIV_W-1:0] div_d, div_q;
  logic             pix_en_d, pix_en_q;
  logic [COL_W-1:0] col_d, col_q;
  logic [ROW_W-1:0] row_d, row_q;
  logic             frame_start_d, frame_start_q;
  sync_t            sync_d, sync_q;
  sync_t            sync_out;

  always_comb begin
    div_d         = div_q;
    col_d         = col_q;
    row_d         = row_q;
    sync_d        = sync_q;
    pix_en_d      = 1'b0;
    frame_start_d = 1'b0;

    if (div_q == DIV_LAST) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end
    // Strobe registered from the next divider value so it is low in reset.
    pix_en_d = (div_d == DIV_LAST);

    if (pix_en_q) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    // Sync is decoded from the next position so it tracks row/col exactly.
    sync_d.hs    = sync_level(HS_POL, (col_d >= COL_W'(HS_START)) && (col_d <= COL_W'(HS_END)));
    sync_d.vs    = sync_level(VS_POL, (row_d >= ROW_W'(VS_START)) && (row_d <= ROW_W'(VS_END)));
    sync_d.blank = (col_d >= COL_W'(H_ACTIVE)) || (row_d >= ROW_W'(V_ACTIVE));

    frame_start_d = pix_en_q && (col_d == '0) && (row_d == '0);
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      div_q         <= '0;
      pix_en_q      <= 1'b0;
      col_q         <= COL_LAST;
      row_q         <= ROW_LAST;
      sync_q        <= SYNC_IDLE;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      pix_en_q      <= pix_en_d;
      col_q         <= col_d;
      row_q         <= row_d;
      sync_q        <= sync_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_SYNC_PIPE_EN
  vga_sync_pipe #(
    .DEPTH   (PIPE_DEPTH),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_pipe (
    .clk   (CLOCK_50),
    .rst_n (reset),
    .en    (pix_en_q),
    .din   (sync_q),
    .dout  (sync_out)
  );
`else
  assign sync_out = sync_q;
`endif

  assign vif.pix_en      = pix_en_q;
  assign vif.col         = col_q;
  assign vif.row         = row_q;
  assign vif.HS          = sync_out.hs;
  assign vif.VS          = sync_out.vs;
  assign vif.blank       = sync_out.blank;
  assign vif.frame_start = frame_start_q;

endmodule

// File: doc/vga_timing.md
# vga_timing

Parametrised VGA raster timing generator, the successor to the fixed 640x480 `vga` block in the Pong display path. It divides `CLOCK_50` into a pixel strobe and runs horizontal and vertical counters. It produces `HS`, `VS`, `blank`, `row` and `col` for any standard mode, plus pixel-strobe and frame-start pulses for the game and renderer logic. An optional sync delay line aligns `HS`/`VS`/`blank` with a pipelined pixel renderer.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width
- `V_BP`, 33, vertical back porch
- `CLK_DIV`, 2, clocks per pixel (≥1)
- `HS_POL`, 0, asserted level of `HS` (0 = active-low)
- `VS_POL`, 0, asserted level of `VS`
- `PIPE_DEPTH`, 2, sync delay in pixel strobes (≥1, used only with `VGA_SYNC_PIPE_EN`)
- `CLOCK_50`  in  1  system clock; single clock domain
- `reset`  in  1  asynchronous, active-low reset
- `pix_en`  out  1  one-clock pixel strobe
- `col`  out  COL_W = $clog2(H_TOTAL)  horizontal position
- `row`  out  ROW_W = $clog2(V_TOTAL)  vertical position
- `HS`  out  1  horizontal sync
- `VS`  out  1  vertical sync
- `blank`  out  1  high outside the active area
- `frame_start`  out  1  one-clock pulse at the start of each frame

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way from the V parameters.
- Divider counts 0..CLK_DIV-1. `pix_en` is high when the divider equals CLK_DIV-1. With CLK_DIV=1, `pix_en` is high on every clock after reset.
- On `pix_en`:
  - `col` increments and wraps H_TOTAL-1→0.
  - On the `col` wrap, `row` increments and wraps V_TOTAL-1→0.
- `HS` is asserted for `col` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
- `VS` is asserted for whole lines with `row` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
- `blank` = (`col` ≥ H_ACTIVE) | (`row` ≥ V_ACTIVE).
- `HS`, `VS` and `blank` are registered and always describe the same pixel as the `row`/`col` currently presented.
- `frame_start` is high for exactly one clock: the first clock on which (`row`,`col`) = (0,0), including the first frame after reset.
- Reset values: `col` = H_TOTAL-1, `row` = V_TOTAL-1, divider = 0, `pix_en` = 0, `blank` = 1, `HS`/`VS` deasserted, `frame_start` = 0. The first `pix_en` after reset moves the raster to (0,0).
- Reset asserted mid-frame forces all reset values immediately (asynchronously). After release, the frame restarts cleanly with no partial-frame `frame_start`.

## Timing
- `row`, `col`, `HS`, `VS` and `blank` change only on the clock edge following `pix_en`. Each value is held for CLK_DIV clocks.
- Latency from `pix_en` high to the new position is one clock.
- Frame period is H_TOTAL·V_TOTAL·CLK_DIV clocks (default 800·525·2).

## Configuration
- Macro: `VGA_SYNC_PIPE_EN`.
- Defined:
  - `HS`, `VS` and `blank` pass through a PIPE_DEPTH-stage shift register that advances on `pix_en`.
  - Reset loads every stage with `blank` = 1 and `HS`/`VS` deasserted.
  - `row`, `col` and `frame_start` are not delayed.
- Undefined: no delay; `PIPE_DEPTH` is ignored.

## Structure
- Package `vga_pkg`:
  - default 640x480@60 timing localparams;
  - `sync_t` packed struct {hs, vs, blank};
  - helper function for the asserted/deasserted level given polarity.
- Sub-module `vga_sync_pipe`: parametrised `sync_t` delay line with enable and async active-low reset. Instantiated only under `VGA_SYNC_PIPE_EN`.

## Test plan
- Small mode for directed tests: H 8/2/3/1 (H_TOTAL 14), V 4/1/2/1 (V_TOTAL 8), CLK_DIV=2.
- Reset: hold `reset`=0 for 5 clocks → `col`=13, `row`=7, `blank`=1, `HS`=`VS`=1, `pix_en`=0, `frame_start`=0. After release, `pix_en` rises on the 2nd clock; the next clock shows (0,0), `blank`=0 and a single-clock `frame_start`.
- Default mode, CLK_DIV=2 → `HS` low exactly 96 strobes (192 clocks) starting when `col`=656; line period 1600 clocks; `VS` low for exactly 2 lines starting at `row`=490.
- Small mode → `frame_start` every 224 clocks; `VS` low across rows 5–6 (28 strobes); `blank`=1 for `col` 8–13 and for `row` 4–7.
- Reset asserted at `row`=2, `col`=5 → outputs take reset values in the same cycle. On restart, no `frame_start` appears until (0,0) is reached.
- CLK_DIV=1 → `pix_en` constant 1 after the first post-reset clock; `col` advances every clock; frame period 112 clocks.
- With `VGA_SYNC_PIPE_EN`, PIPE_DEPTH=2, small mode → `HS` falls 2 strobes (4 clocks) after `col` reaches 10. Without the macro, `HS` falls coincident with `col`=10.
